sobel_stream: RTL and testbench
===============================

SOBEL_STREAM -- requirements
Module: sobel_stream

Interface
REQ-001 Parameter IMG_WIDTH, default 695: pixels per line; legal range 3..4096.
REQ-002 Parameter IMG_HEIGHT, default 480: lines per frame; legal range 3..4096.
REQ-003 Parameter PIX_W, default 8: unsigned pixel width in bits; legal range 4..16.
REQ-004 Parameter MODE, default 0: 0 = X gradient, 1 = Y gradient, 2 = magnitude |Gx|+|Gy|.
REQ-005 clock  input  1  sole clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 en  input  1  pipeline enable; 0 freezes all state.
REQ-008 in_valid  input  1  in_data holds a pixel.
REQ-009 in_data  input  PIX_W  pixel, raster order, unsigned.
REQ-010 out_valid  output  1  out_data holds a result.
REQ-011 out_data  output  PIX_W  filtered pixel.
REQ-012 out_eol  output  1  high with the last interior result of a line.
REQ-013 out_eof  output  1  high with the last interior result of a frame.

Function
REQ-014 A pixel is accepted in a cycle where en=1 and in_valid=1 and reset=0; in_valid with en=0 is ignored.
REQ-015 Column counter (0..IMG_WIDTH-1) and row counter (0..IMG_HEIGHT-1) advance on each acceptance; column wraps to 0 and row increments; after (IMG_WIDTH-1, IMG_HEIGHT-1) both wrap to 0 (next frame).
REQ-016 Two line buffers of IMG_WIDTH entries plus a 3x3 window register; all shift only on acceptance.
REQ-017 Window for centre (r,c) is complete when pixel (r+1,c+1) is accepted; results exist only for interior centres 1<=r<=IMG_HEIGHT-2, 1<=c<=IMG_WIDTH-2, i.e. (IMG_WIDTH-2)*(IMG_HEIGHT-2) results per frame.
REQ-018 Gx = (p[r-1][c+1] + 2p[r][c+1] + p[r+1][c+1]) - (p[r-1][c-1] + 2p[r][c-1] + p[r+1][c-1]).
REQ-019 Gy = (p[r+1][c-1] + 2p[r+1][c] + p[r+1][c+1]) - (p[r-1][c-1] + 2p[r-1][c] + p[r-1][c+1]).
REQ-020 Gradients are signed, PIX_W+4 bits wide; no overflow possible.
REQ-021 MODE 0/1: out_data = clamp(G/8 + 2^(PIX_W-1)); MODE 2: out_data = clamp((|Gx|+|Gy|)/8); division truncates toward zero; clamp range 0..2^PIX_W-1.
REQ-022 Pipeline: stage 1 registers gradient(s) on the accepting cycle t; stage 2 registers scaled result; out_valid/out_data/out_eol/out_eof appear at t+2 when en=1 at t+1.
REQ-023 Each stage advances only when en=1; en=0 holds every register, including outputs.
REQ-024 out_valid is high for exactly one enabled cycle per interior result; a stage with no valid data propagates out_valid=0.
REQ-025 Input bubbles (in_valid=0, en=1) insert out_valid=0 bubbles; results emerge in raster order with no loss or duplication.
REQ-026 out_eol = out_valid and c = IMG_WIDTH-2; out_eof = out_valid and (r,c) = (IMG_HEIGHT-2, IMG_WIDTH-2); out_eof implies out_eol.
REQ-027 Illegal parameter values are a compile-time error.

Reset
REQ-028 reset=1 at a clock edge overrides en and in_valid, including mid-frame.
REQ-029 Reset values: counters 0, pipeline valid flags 0, out_valid 0, out_data 0, out_eol 0, out_eof 0.
REQ-030 Line-buffer and window contents need no reset; no result may depend on them before being refilled (guaranteed by REQ-017).
REQ-031 First pixel accepted after reset is pixel (0,0) of a new frame.

Verification (IMG_WIDTH=5, IMG_HEIGHT=4, PIX_W=8 unless stated)
REQ-032 MODE 0, constant 100 frame, en=1 -> 6 results all 128; out_eol on results 3 and 6; out_eof on result 6 only.
REQ-033 MODE 0, columns 0-1 = 0, columns 2-4 = 80 -> each row outputs 168, 168, 128; mirrored step -> 88, 88, 128.
REQ-034 MODE 2, columns 0-1 = 0, columns 2-4 = 255 -> each row outputs 127, 127, 0; MODE 1 on the transposed pattern (rows 0-1 = 0, rows 2-3 = 255, IMG_HEIGHT=4) -> 255 for both result rows.
REQ-035 Random en and in_valid toggling over 3 frames -> result stream identical to the en=1 reference; out_data held stable while en=0.
REQ-036 reset pulsed after 7 pixels of a frame, then a full frame -> no out_valid during or after reset until the new frame's (2,2) pixel is accepted; exactly 6 correct results follow.
REQ-037 Two back-to-back frames, no gaps -> 12 results, 2 out_eof pulses, correct values with no cross-frame contamination.

Source files
------------

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel filter over a raster pixel stream with a two-stage result pipeline.
// Emits one result per interior pixel, flagged with end-of-line/end-of-frame markers.
module sobel_stream #(
    parameter int IMG_WIDTH  = 695,
    parameter int IMG_HEIGHT = 480,
    parameter int PIX_W      = 8,
    parameter int MODE       = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_data,
    output logic             out_valid,
    output logic [PIX_W-1:0] out_data,
    output logic             out_eol,
    output logic             out_eof
);

    localparam int CW   = $clog2(IMG_WIDTH);
    localparam int RW   = $clog2(IMG_HEIGHT);
    localparam int GW   = PIX_W + 4;
    localparam int BIAS = 2 ** (PIX_W - 1);
    localparam int PMAX = 2 ** PIX_W - 1;

    if (IMG_WIDTH < 3 || IMG_WIDTH > 4096) begin : g_bad_width
        $error("sobel_stream: IMG_WIDTH must be in 3..4096");
    end
    if (IMG_HEIGHT < 3 || IMG_HEIGHT > 4096) begin : g_bad_height
        $error("sobel_stream: IMG_HEIGHT must be in 3..4096");
    end
    if (PIX_W < 4 || PIX_W > 16) begin : g_bad_pix_w
        $error("sobel_stream: PIX_W must be in 4..16");
    end
    if (MODE < 0 || MODE > 2) begin : g_bad_mode
        $error("sobel_stream: MODE must be 0, 1 or 2");
    end

    function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
        return signed'({4'b0000, p});
    endfunction

    logic          accept;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          last_col;
    logic          last_row;
    logic          win_done;

    always_comb begin
        accept   = en && in_valid && !reset;
        last_col = (col == CW'(IMG_WIDTH - 1));
        last_row = (row == RW'(IMG_HEIGHT - 1));
        win_done = (col >= CW'(2)) && (row >= RW'(2));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // lb_near holds the previous row, lb_far the row before that, both indexed by column.
    logic [PIX_W-1:0] lb_near [IMG_WIDTH];
    logic [PIX_W-1:0] lb_far  [IMG_WIDTH];
    logic [PIX_W-1:0] col_top;
    logic [PIX_W-1:0] col_mid;
    logic [PIX_W-1:0] col_bot;

    always_comb begin
        col_top = lb_far[col];
        col_mid = lb_near[col];
        col_bot = in_data;
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            lb_far[col]  <= lb_near[col];
            lb_near[col] <= in_data;
        end
    end

    // Window keeps the two older columns; the newest column is the live line-buffer read.
    logic [PIX_W-1:0] win_l [3];
    logic [PIX_W-1:0] win_m [3];

    always_ff @(posedge clock) begin
        if (accept) begin
            win_l[0] <= win_m[0];
            win_l[1] <= win_m[1];
            win_l[2] <= win_m[2];
            win_m[0] <= col_top;
            win_m[1] <= col_mid;
            win_m[2] <= col_bot;
        end
    end

    logic signed [GW-1:0] gx;
    logic signed [GW-1:0] gy;
    logic signed [GW-1:0] abs_x;
    logic signed [GW-1:0] abs_y;
    logic signed [GW-1:0] g_sel;

    always_comb begin
        gx = (ext(col_top) + (ext(col_mid) <<< 1) + ext(col_bot))
           - (ext(win_l[0]) + (ext(win_l[1]) <<< 1) + ext(win_l[2]));
        gy = (ext(win_l[2]) + (ext(win_m[2]) <<< 1) + ext(col_bot))
           - (ext(win_l[0]) + (ext(win_m[0]) <<< 1) + ext(col_top));
        abs_x = gx[GW-1] ? -gx : gx;
        abs_y = gy[GW-1] ? -gy : gy;
        if (MODE == 0) begin
            g_sel = gx;
        end else if (MODE == 1) begin
            g_sel = gy;
        end else begin
            g_sel = abs_x + abs_y;
        end
    end

    logic                 s1_valid;
    logic                 s1_eol;
    logic                 s1_eof;
    logic signed [GW-1:0] s1_g;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_eol   <= 1'b0;
            s1_eof   <= 1'b0;
            s1_g     <= '0;
        end else if (en) begin
            s1_valid <= accept && win_done;
            s1_eol   <= accept && win_done && last_col;
            s1_eof   <= accept && win_done && last_col && last_row;
            s1_g     <= g_sel;
        end
    end

    logic signed [GW-1:0] q;
    logic [PIX_W-1:0]     res;

    // Adding 7 before the arithmetic shift turns floor division into truncation toward zero.
    always_comb begin
        if (MODE == 2) begin
            q = s1_g >>> 3;
        end else begin
            q = (s1_g + (s1_g[GW-1] ? GW'(7) : GW'(0))) >>> 3;
            q = q + GW'(BIAS);
        end
        if (q < 0) begin
            res = '0;
        end else if (q > GW'(PMAX)) begin
            res = '1;
        end else begin
            res = q[PIX_W-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end else if (en) begin
            out_valid <= s1_valid;
            out_eol   <= s1_eol;
            out_eof   <= s1_eof;
            if (s1_valid) begin
                out_data <= res;
            end
        end
    end

endmodule

// File: tb/tb_sobel_stream.sv
// Self-checking bench for sobel_stream: three instances (MODE 0/1/2) share one stimulus stream
// and are checked every cycle against a frame-level model plus hand-computed literal sequences.
module tb_sobel_stream;

    localparam int W  = 5;
    localparam int H  = 4;
    localparam int PW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          en;
    logic          in_valid;
    logic [PW-1:0] in_data;
    logic          o_valid [3];
    logic [PW-1:0] o_data  [3];
    logic          o_eol   [3];
    logic          o_eof   [3];

    sobel_stream #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW), .MODE(0)) dut0 (
        .clock(clock), .reset(reset), .en(en), .in_valid(in_valid), .in_data(in_data),
        .out_valid(o_valid[0]), .out_data(o_data[0]), .out_eol(o_eol[0]), .out_eof(o_eof[0]));
    sobel_stream #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW), .MODE(1)) dut1 (
        .clock(clock), .reset(reset), .en(en), .in_valid(in_valid), .in_data(in_data),
        .out_valid(o_valid[1]), .out_data(o_data[1]), .out_eol(o_eol[1]), .out_eof(o_eof[1]));
    sobel_stream #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW), .MODE(2)) dut2 (
        .clock(clock), .reset(reset), .en(en), .in_valid(in_valid), .in_data(in_data),
        .out_valid(o_valid[2]), .out_data(o_data[2]), .out_eol(o_eol[2]), .out_eof(o_eof[2]));

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    bit run_chk = 1'b0;

    // Model state: current frame image, raster position, and the expected output two enabled edges on.
    int img [H][W];
    int mrow, mcol;
    bit s1_v, s1_eol, s1_eof;
    int s1_val [3];
    bit exp_v, exp_eol, exp_eof;
    int exp_val [3];
    bit fresh = 1'b0;

    int cap_d0 [$];
    int cap_d1 [$];
    int cap_d2 [$];
    bit cap_eol [$];
    bit cap_eof [$];

    function automatic int clampv(input int v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    function automatic int absv(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int sobel_ref(input int m, input int r, input int c);
        int gx, gy;
        gx = (img[r-1][c+1] + 2 * img[r][c+1] + img[r+1][c+1])
           - (img[r-1][c-1] + 2 * img[r][c-1] + img[r+1][c-1]);
        gy = (img[r+1][c-1] + 2 * img[r+1][c] + img[r+1][c+1])
           - (img[r-1][c-1] + 2 * img[r-1][c] + img[r-1][c+1]);
        if (m == 0) return clampv(gx / 8 + 128);
        if (m == 1) return clampv(gy / 8 + 128);
        return clampv((absv(gx) + absv(gy)) / 8);
    endfunction

    initial begin
        forever begin
            @(posedge clock);
            if (reset) begin
                mrow = 0; mcol = 0;
                s1_v = 0; s1_eol = 0; s1_eof = 0;
                exp_v = 0; exp_eol = 0; exp_eof = 0;
                fresh = 0;
            end else if (en) begin
                exp_v = s1_v; exp_eol = s1_eol; exp_eof = s1_eof;
                for (int m = 0; m < 3; m++) exp_val[m] = s1_val[m];
                fresh = 1;
                s1_v = 0; s1_eol = 0; s1_eof = 0;
                if (in_valid) begin
                    img[mrow][mcol] = int'(in_data);
                    if (mrow >= 2 && mcol >= 2) begin
                        s1_v = 1;
                        for (int m = 0; m < 3; m++) s1_val[m] = sobel_ref(m, mrow - 1, mcol - 1);
                        s1_eol = (mcol == W - 1);
                        s1_eof = (mcol == W - 1) && (mrow == H - 1);
                    end
                    if (mcol == W - 1) begin
                        mcol = 0;
                        mrow = (mrow == H - 1) ? 0 : mrow + 1;
                    end else begin
                        mcol = mcol + 1;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (run_chk) begin
                for (int m = 0; m < 3; m++) begin
                    tests++;
                    if (o_valid[m] !== exp_v || o_eol[m] !== (exp_v && exp_eol) ||
                        o_eof[m] !== (exp_v && exp_eof) ||
                        (exp_v && o_data[m] !== PW'(exp_val[m]))) begin
                        fails++;
                        $display("FAIL stream_mode%0d t=%0t: valid/data/eol/eof got %b/%0d/%b/%b expected %b/%0d/%b/%b",
                                 m, $time, o_valid[m], o_data[m], o_eol[m], o_eof[m],
                                 exp_v, exp_val[m], exp_v && exp_eol, exp_v && exp_eof);
                    end
                end
                if (fresh) begin
                    if (o_valid[0] === 1'b1) begin
                        cap_d0.push_back(int'(o_data[0]));
                        cap_eol.push_back(o_eol[0]);
                        cap_eof.push_back(o_eof[0]);
                    end
                    if (o_valid[1] === 1'b1) cap_d1.push_back(int'(o_data[1]));
                    if (o_valid[2] === 1'b1) cap_d2.push_back(int'(o_data[2]));
                end
                fresh = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int cap_at(input int m, input int i);
        if (m == 0) return (i < cap_d0.size()) ? cap_d0[i] : -1;
        if (m == 1) return (i < cap_d1.size()) ? cap_d1[i] : -1;
        return (i < cap_d2.size()) ? cap_d2[i] : -1;
    endfunction

    // Six captured results starting at off must read a,b,c,a,b,c (two result rows).
    task automatic chk_seq(input string name, input int m, input int off, input int a, input int b, input int c);
        int e;
        for (int i = 0; i < 6; i++) begin
            e = (i % 3 == 0) ? a : ((i % 3 == 1) ? b : c);
            chk($sformatf("%s[%0d]", name, i), cap_at(m, off + i), e);
        end
    endtask

    function automatic int eol_mask();
        int k = 0;
        for (int i = 0; i < cap_eol.size() && i < 6; i++) if (cap_eol[i]) k |= (1 << i);
        return k;
    endfunction

    function automatic int eof_mask();
        int k = 0;
        for (int i = 0; i < cap_eof.size() && i < 6; i++) if (cap_eof[i]) k |= (1 << i);
        return k;
    endfunction

    function automatic int eof_count();
        int k = 0;
        foreach (cap_eof[i]) if (cap_eof[i]) k++;
        return k;
    endfunction

    task automatic clear_caps();
        cap_d0.delete(); cap_d1.delete(); cap_d2.delete();
        cap_eol.delete(); cap_eof.delete();
    endtask

    function automatic int pix(input int pat, input int seed, input int r, input int c);
        case (pat)
            0: return 100;
            1: return (c >= 2) ? 80 : 0;
            2: return (c < 2) ? 80 : 0;
            3: return (c >= 2) ? 255 : 0;
            4: return (r >= 2) ? 255 : 0;
            default: return (r * 71 + c * 29 + seed * 113 + r * c * seed * 17) % 256;
        endcase
    endfunction

    task automatic send_pix(input int v, input bit gaps);
        bit done = 0;
        int tries = 0;
        while (!done) begin
            en       = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (tries >= 8) begin
                en = 1'b1;
                in_valid = 1'b1;
            end
            in_data = PW'(v);
            @(negedge clock);
            done = en && in_valid;
            tries++;
        end
    endtask

    task automatic send_frame(input int pat, input int seed, input bit gaps);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                send_pix(pix(pat, seed, r, c), gaps);
    endtask

    task automatic idle(input int n);
        en = 1'b1;
        in_valid = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; en = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(negedge clock);
        for (int m = 0; m < 3; m++) begin
            chk($sformatf("reset_valid_m%0d", m), o_valid[m], 0);
            chk($sformatf("reset_data_m%0d", m), o_data[m], 0);
            chk($sformatf("reset_eol_m%0d", m), o_eol[m], 0);
            chk($sformatf("reset_eof_m%0d", m), o_eof[m], 0);
        end
        reset = 1'b0;
        run_chk = 1'b1;

        clear_caps();
        send_frame(0, 0, 0);
        idle(4);
        chk_seq("const_m0", 0, 0, 128, 128, 128);
        chk_seq("const_m1", 1, 0, 128, 128, 128);
        chk_seq("const_m2", 2, 0, 0, 0, 0);
        chk("const_count", cap_d0.size(), 6);
        chk("const_eol_mask", eol_mask(), 6'b100100);
        chk("const_eof_mask", eof_mask(), 6'b100000);

        clear_caps();
        send_frame(1, 0, 0);
        idle(4);
        chk_seq("step80_m0", 0, 0, 168, 168, 128);
        chk_seq("step80_m1", 1, 0, 128, 128, 128);
        chk_seq("step80_m2", 2, 0, 40, 40, 0);

        clear_caps();
        send_frame(2, 0, 0);
        idle(4);
        chk_seq("mirror80_m0", 0, 0, 88, 88, 128);

        clear_caps();
        send_frame(3, 0, 0);
        idle(4);
        chk_seq("step255_m2", 2, 0, 127, 127, 0);
        chk_seq("step255_m0", 0, 0, 255, 255, 128);

        clear_caps();
        send_frame(4, 0, 0);
        idle(4);
        chk_seq("rows255_m1", 1, 0, 255, 255, 255);
        chk_seq("rows255_m0", 0, 0, 128, 128, 128);
        chk_seq("rows255_m2", 2, 0, 127, 127, 127);

        clear_caps();
        send_frame(5, 1, 1);
        send_frame(5, 2, 1);
        send_frame(5, 3, 1);
        idle(4);
        chk("gaps_count", cap_d0.size(), 18);
        chk("gaps_count_m2", cap_d2.size(), 18);
        chk("gaps_eof_count", eof_count(), 3);

        clear_caps();
        for (int i = 0; i < 7; i++) send_pix(pix(5, 7, i / W, i % W), 0);
        reset = 1'b1; en = 1'b1; in_valid = 1'b1; in_data = 8'd55;
        repeat (2) @(negedge clock);
        reset = 1'b0; in_valid = 1'b0;
        chk("reset_mid_valid", o_valid[0], 0);
        send_frame(5, 8, 0);
        idle(4);
        chk("reset_mid_count", cap_d0.size(), 6);
        chk("reset_mid_eof_count", eof_count(), 1);

        clear_caps();
        send_frame(5, 11, 0);
        send_frame(3, 0, 0);
        idle(4);
        chk("b2b_count", cap_d0.size(), 12);
        chk("b2b_eof_count", eof_count(), 2);
        chk_seq("b2b_second_m0", 0, 6, 255, 255, 128);

        run_chk = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
